// File: rtl/rx_timing_ctrl.sv
// rtl/rx_timing_ctrl.sv - UART receive timing and control stage
//
// Purpose:
//   Finds the start bit and confirms it at mid-bit. It then pulses shift_strobe
//   at the centre of each of the 8 data bits and the stop bit. After the 9th
//   strobe it inspects the stop bit that the downstream shift register captured.
//   A good stop bit pulses load_buffer. A bad stop bit sets the sticky
//   framing_error flag.
//
// Ports:
//   clk            in   system clock, rising edge
//   rst            in   synchronous active-high reset
//   serial_in      in   synchronized receive line, idle high
//   stop_bit       in   bit 8 of the receive shift register
//   shift_strobe   out  one-cycle pulse at each bit centre
//   load_buffer    out  one-cycle pulse when the shift register holds a good byte
//   framing_error  out  sticky, last frame had a zero stop bit
//   rx_busy        out  high from start-edge detection to frame end
//   err_count      out  saturating framing-error count (RX_ERR_COUNT_EN only)
//
// Optional feature macro: RX_ERR_COUNT_EN

module rx_timing_ctrl #(
  parameter int CLKS_PER_BIT = 10,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  input  logic       stop_bit,
  output logic       shift_strobe,
  output logic       load_buffer,
  output logic       framing_error,
  output logic       rx_busy
`ifdef RX_ERR_COUNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LP_LAST    = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] LP_HALF_M1 = CW'(HALF_BIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START_CHK,
    ST_RECV,
    ST_CHECK
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [CW-1:0] r_clk_cnt;
  logic [3:0]    r_bit_cnt;
  logic          r_prev_in;
  logic          r_framing_error;

  logic w_start_edge;
  logic w_half_point;
  logic w_bit_end;

  // A falling edge only counts in IDLE, so line activity mid-frame never restarts it.
  assign w_start_edge = (r_state == ST_IDLE) && r_prev_in && !serial_in;
  // clk_cnt is cleared at the edge cycle E, so it holds HALF_BIT-1 in cycle E+HALF_BIT.
  assign w_half_point = (r_clk_cnt == LP_HALF_M1);
  assign w_bit_end    = (r_clk_cnt == LP_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start_edge) w_next_state = ST_START_CHK;
      end
      ST_START_CHK: begin
        if (w_half_point) w_next_state = serial_in ? ST_IDLE : ST_RECV;
      end
      ST_RECV: begin
        if (w_bit_end && (r_bit_cnt == 4'd8)) w_next_state = ST_CHECK;
      end
      ST_CHECK: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Output decode.
  // load_buffer depends on stop_bit, but never on serial_in.
  always_comb begin
    shift_strobe  = 1'b0;
    load_buffer   = 1'b0;
    rx_busy       = (r_state != ST_IDLE);
    framing_error = r_framing_error;
    case (r_state)
      ST_RECV:  shift_strobe = w_bit_end;
      ST_CHECK: load_buffer  = stop_bit;
      default: ;
    endcase
  end

  // Counters, edge-detect history and the sticky error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_cnt       <= '0;
      r_bit_cnt       <= 4'd0;
      r_prev_in       <= 1'b1;
      r_framing_error <= 1'b0;
    end else begin
      r_prev_in <= serial_in;
      case (r_state)
        ST_IDLE: begin
          r_clk_cnt <= '0;
          r_bit_cnt <= 4'd0;
          if (w_start_edge) r_framing_error <= 1'b0;
        end
        ST_START_CHK: begin
          if (w_half_point) begin
            r_clk_cnt <= '0;
            r_bit_cnt <= 4'd0;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        ST_RECV: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            r_bit_cnt <= r_bit_cnt + 4'd1;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        ST_CHECK: begin
          r_clk_cnt <= '0;
          r_bit_cnt <= 4'd0;
          if (!stop_bit) r_framing_error <= 1'b1;
        end
        default: begin
          r_clk_cnt <= '0;
          r_bit_cnt <= 4'd0;
        end
      endcase
    end
  end

`ifdef RX_ERR_COUNT_EN
  logic [7:0] r_err_count;

  // Counts on the same edge that sets framing_error. Glitched starts never reach CHECK.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_count <= 8'd0;
    end else if ((r_state == ST_CHECK) && !stop_bit && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign err_count = r_err_count;
`endif

endmodule

// File: tb/tb_rx_timing_ctrl.sv
// tb/tb_rx_timing_ctrl.sv - scoreboard bench for rx_timing_ctrl
module tb_rx_timing_ctrl;

  localparam int K_BRISE  = 0;
  localparam int K_FEFALL = 1;
  localparam int K_STROBE = 2;
  localparam int K_LOAD   = 3;
  localparam int K_FERISE = 4;
  localparam int K_BFALL  = 5;

  typedef struct {
    int         kind;
    int         cyc;
    logic [7:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic serial_in = 1'b1;
  logic stop_bit;
  logic shift_strobe, load_buffer, framing_error, rx_busy;
`ifdef RX_ERR_COUNT_EN
  logic [7:0] err_count;
`endif

  logic [8:0] sr = 9'd0;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  logic fe_now = 1'b0;
  logic p_busy = 1'b0;
  logic p_fe = 1'b0;
  ev_t q[$];

  rx_timing_ctrl #(.CLKS_PER_BIT(10)) dut (
    .clk           (clk),
    .rst           (rst),
    .serial_in     (serial_in),
    .stop_bit      (stop_bit),
    .shift_strobe  (shift_strobe),
    .load_buffer   (load_buffer),
    .framing_error (framing_error),
    .rx_busy       (rx_busy)
`ifdef RX_ERR_COUNT_EN
    ,
    .err_count     (err_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Downstream 9-bit shift register: LSB first, with the stop bit ending in bit 8.
  always @(posedge clk) if (shift_strobe) sr <= {serial_in, sr[8:1]};
  assign stop_bit = sr[8];

  function automatic string kname(input int k);
    case (k)
      K_BRISE:  return "busy_rise";
      K_FEFALL: return "fe_fall";
      K_STROBE: return "strobe";
      K_LOAD:   return "load";
      K_FERISE: return "fe_rise";
      default:  return "busy_fall";
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int c, input logic [7:0] d);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.data = d;
    q.push_back(e);
  endtask

  task automatic take(input int kind);
    ev_t e;
    if (q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_%s: actual=event at cycle %0d required=none", kname(kind), cyc);
    end else begin
      e = q.pop_front();
      chk({"kind_", kname(kind)}, kind, e.kind);
      chk({"cycle_", kname(kind)}, cyc, e.cyc);
      if (kind == K_LOAD) chk("load_data", int'(sr[7:0]), int'(e.data));
    end
  endtask

  // Monitor: turns DUT output activity into events, in a fixed order within a cycle.
  always @(negedge clk) begin
    if (rx_busy && !p_busy)        take(K_BRISE);
    if (!framing_error && p_fe)    take(K_FEFALL);
    if (shift_strobe)              take(K_STROBE);
    if (load_buffer)               take(K_LOAD);
    if (framing_error && !p_fe)    take(K_FERISE);
    if (!rx_busy && p_busy)        take(K_BFALL);
    p_busy = rx_busy;
    p_fe   = framing_error;
  end

  task automatic tick(input logic v);
    @(posedge clk);
    #1;
    serial_in = v;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b1);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    int e;
    logic v;
    for (int j = 0; j < 100; j++) begin
      if (j < 10)      v = 1'b0;
      else if (j < 90) v = d[(j - 10) / 10];
      else             v = stop;
      tick(v);
      if (j == 0) begin
        e = cyc;
        push(K_BRISE, e + 1, 8'h00);
        if (fe_now) push(K_FEFALL, e + 1, 8'h00);
        for (int k = 1; k <= 9; k++) push(K_STROBE, e + 5 + 10 * k, 8'h00);
        if (stop) push(K_LOAD, e + 96, d);
        else      push(K_FERISE, e + 97, 8'h00);
        push(K_BFALL, e + 97, 8'h00);
        fe_now = !stop;
      end
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_strobe"}, int'(shift_strobe), 0);
    chk({tag, "_load"}, int'(load_buffer), 0);
    chk({tag, "_fe"}, int'(framing_error), 0);
    chk({tag, "_busy"}, int'(rx_busy), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1; rst = 1'b1; serial_in = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1; rst = 1'b0;
    fe_now = 1'b0;
  endtask

  initial begin
    int e;
    logic [7:0] d;
    logic v;

    // Reset state
    repeat (3) @(posedge clk);
    #3;
    check_outputs_zero("reset");
`ifdef RX_ERR_COUNT_EN
    chk("reset_err_count", int'(err_count), 0);
`endif
    @(posedge clk); #1; rst = 1'b0;
    idle(5);

    // Good frame
    send_frame(8'hA5, 1'b1);
    idle(3);

    // Glitch: low for 3 cycles, then high again before the mid-bit check
    tick(1'b0);
    e = cyc;
    push(K_BRISE, e + 1, 8'h00);
    push(K_BFALL, e + 6, 8'h00);
    tick(1'b0);
    tick(1'b0);
    tick(1'b1);
    idle(8);
    send_frame(8'h3C, 1'b1);
    idle(3);

    // Framing error; the flag must hold through the idle gap
    send_frame(8'h55, 1'b0);
    idle(5);
    #3;
    chk("fe_held", int'(framing_error), 1);

    // Back-to-back frames; the first one also clears the error flag
    send_frame(8'h0F, 1'b1);
    send_frame(8'hF0, 1'b1);
    idle(3);

    // Reset in mid-frame at E+40
    d = 8'hA5;
    for (int j = 0; j < 40; j++) begin
      v = (j < 10) ? 1'b0 : d[(j - 10) / 10];
      tick(v);
      if (j == 0) begin
        e = cyc;
        push(K_BRISE, e + 1, 8'h00);
        push(K_STROBE, e + 15, 8'h00);
        push(K_STROBE, e + 25, 8'h00);
        push(K_STROBE, e + 35, 8'h00);
        push(K_BFALL, e + 41, 8'h00);
      end
    end
    @(posedge clk); #1; rst = 1'b1; serial_in = 1'b1;
    @(posedge clk); #1;
    #3;
    check_outputs_zero("midreset");
    @(posedge clk); #1; rst = 1'b0;
    fe_now = 1'b0;
    idle(20);
    send_frame(8'hA5, 1'b1);
    idle(3);

`ifdef RX_ERR_COUNT_EN
    do_reset();
    idle(3);
    for (int i = 0; i < 3; i++) begin
      send_frame(8'h81, 1'b0);
      idle(3);
    end
    chk("err_count_3", int'(err_count), 3);
    for (int i = 0; i < 253; i++) begin
      send_frame(8'h18, 1'b0);
      idle(3);
    end
    chk("err_count_sat", int'(err_count), 255);
`endif

    idle(10);
    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
